// File: rtl/dcache_ctrl_if.sv
// Bus bundle between the data-cache controller, the CPU, the line memory and the tag/data array.
// The controller uses the slave view; the surrounding system uses the master view.
interface dcache_ctrl_if;
    logic [31:0]  cpu_addr_i;
    logic [31:0]  cpu_data_i;
    logic         cpu_MemRead_i;
    logic         cpu_MemWrite_i;
    logic [31:0]  cpu_data_o;
    logic         cpu_stall_o;

    logic [31:0]  mem_addr_o;
    logic [255:0] mem_data_o;
    logic         mem_enable_o;
    logic         mem_write_o;
    logic [255:0] mem_data_i;
    logic         mem_ack_i;

    logic [3:0]   sram_addr_o;
    logic [24:0]  sram_tag_o;
    logic [255:0] sram_data_o;
    logic         sram_enable_o;
    logic         sram_write_o;
    logic [24:0]  sram_tag_i;
    logic [255:0] sram_data_i;
    logic         sram_hit_i;

    modport slave (
        input  cpu_addr_i, cpu_data_i, cpu_MemRead_i, cpu_MemWrite_i,
        input  mem_data_i, mem_ack_i,
        input  sram_tag_i, sram_data_i, sram_hit_i,
        output cpu_data_o, cpu_stall_o,
        output mem_addr_o, mem_data_o, mem_enable_o, mem_write_o,
        output sram_addr_o, sram_tag_o, sram_data_o, sram_enable_o, sram_write_o
    );

    modport master (
        output cpu_addr_i, cpu_data_i, cpu_MemRead_i, cpu_MemWrite_i,
        output mem_data_i, mem_ack_i,
        output sram_tag_i, sram_data_i, sram_hit_i,
        input  cpu_data_o, cpu_stall_o,
        input  mem_addr_o, mem_data_o, mem_enable_o, mem_write_o,
        input  sram_addr_o, sram_tag_o, sram_data_o, sram_enable_o, sram_write_o
    );
endinterface

// File: rtl/dcache_ctrl.sv
// Write-back, write-allocate data-cache controller: 16 sets x 2 ways x 32-byte lines.
// Hits resolve combinationally; misses run lookup, optional writeback, line fill, then replay.
module dcache_ctrl (
    input  logic         clk_i,
    input  logic         rst_i,
    dcache_ctrl_if.slave bus
);

    typedef enum logic [2:0] {
        StIdle,
        StMiss,
        StWriteback,
        StReadMiss,
        StReadMissOk
    } state_e;

    state_e       state_q, state_d;
    logic [255:0] victim_line_q, victim_line_d;
    logic [31:0]  victim_addr_q, victim_addr_d;

    logic         req;
    logic         is_store;
    logic [3:0]   index;
    logic [2:0]   word;
    logic [22:0]  tag;
    logic [31:0]  line_addr;
    logic [31:0]  hit_word;
    logic [255:0] merged_line;
    logic         unused_addr_bits;

    assign req              = bus.cpu_MemRead_i | bus.cpu_MemWrite_i;
    assign is_store         = bus.cpu_MemWrite_i;
    assign index            = bus.cpu_addr_i[8:5];
    assign word             = bus.cpu_addr_i[4:2];
    assign tag              = bus.cpu_addr_i[31:9];
    assign line_addr        = {bus.cpu_addr_i[31:5], 5'b0};
    assign unused_addr_bits = ^bus.cpu_addr_i[1:0];

    assign bus.sram_addr_o   = index;
    assign bus.sram_enable_o = req | (state_q != StIdle);

    assign hit_word = bus.sram_data_i[{word, 5'b0} +: 32];

    // Store hit: the addressed word is replaced, the other seven are passed through.
    always_comb begin
        merged_line                      = bus.sram_data_i;
        merged_line[{word, 5'b0} +: 32]  = bus.cpu_data_i;
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q       <= StIdle;
            victim_line_q <= '0;
            victim_addr_q <= '0;
        end else begin
            state_q       <= state_d;
            victim_line_q <= victim_line_d;
            victim_addr_q <= victim_addr_d;
        end
    end

    always_comb begin
        state_d          = state_q;
        victim_line_d    = victim_line_q;
        victim_addr_d    = victim_addr_q;

        bus.cpu_stall_o  = 1'b0;
        bus.cpu_data_o   = '0;
        bus.mem_addr_o   = line_addr;
        bus.mem_data_o   = '0;
        bus.mem_enable_o = 1'b0;
        bus.mem_write_o  = 1'b0;
        bus.sram_tag_o   = {2'b00, tag};
        bus.sram_data_o  = '0;
        bus.sram_write_o = 1'b0;

        case (state_q)
            StIdle: begin
                if (req) begin
                    if (bus.sram_hit_i) begin
                        bus.cpu_data_o = hit_word;
                        if (is_store) begin
                            bus.sram_write_o = 1'b1;
                            bus.sram_tag_o   = {2'b11, tag};
                            bus.sram_data_o  = merged_line;
                        end
                    end else begin
                        bus.cpu_stall_o = 1'b1;
                        state_d         = StMiss;
                    end
                end
            end

            StMiss: begin
                bus.cpu_stall_o = 1'b1;
                // Only a valid and dirty victim needs to be written back before the fill.
                if (bus.sram_tag_i[24] & bus.sram_tag_i[23]) begin
                    victim_line_d = bus.sram_data_i;
                    victim_addr_d = {bus.sram_tag_i[22:0], index, 5'b0};
                    state_d       = StWriteback;
                end else begin
                    state_d = StReadMiss;
                end
            end

            StWriteback: begin
                bus.cpu_stall_o  = 1'b1;
                bus.mem_enable_o = 1'b1;
                bus.mem_write_o  = 1'b1;
                bus.mem_addr_o   = victim_addr_q;
                bus.mem_data_o   = victim_line_q;
                if (bus.mem_ack_i) begin
                    state_d = StReadMiss;
                end
            end

            StReadMiss: begin
                bus.cpu_stall_o  = 1'b1;
                bus.mem_enable_o = 1'b1;
                bus.mem_addr_o   = line_addr;
                if (bus.mem_ack_i) begin
                    bus.sram_write_o = 1'b1;
                    bus.sram_tag_o   = {2'b10, tag};
                    bus.sram_data_o  = bus.mem_data_i;
                    state_d          = StReadMissOk;
                end
            end

            StReadMissOk: begin
                // Spacer cycle so the freshly written line is visible to the replayed lookup.
                bus.cpu_stall_o = 1'b1;
                state_d         = StIdle;
            end

            default: begin
                state_d = StIdle;
            end
        endcase

        if (rst_i) begin
            bus.mem_enable_o = 1'b0;
            bus.mem_write_o  = 1'b0;
            bus.sram_write_o = 1'b0;
        end
    end

endmodule
